// File: rtl/nes_bus_mem_bridge.sv
// Byte-wide NES host bus to 32-bit work-memory bridge with a posted-write FIFO.
// Optional one-word read line buffer when BRIDGE_READ_CACHE_EN is defined.
module nes_bus_mem_bridge #(
  parameter int WBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [14:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ready,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  output logic [12:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_CAPTURE} state_t;

  typedef struct packed {
    logic [12:0] word;
    logic [1:0]  lane;
    logic [7:0]  data;
  } wentry_t;

  state_t        state_q, state_d;
  wentry_t       fifo_q [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          live_q;
  logic [1:0]    rd_lane_q;

  logic    fifo_empty, fifo_full, wr_ready, rd_ready;
  logic    push, rd_accept, rd_hit, pop, issue_wr, issue_rd, capture, fifo_store;
  wentry_t in_entry, wr_entry;
  logic [7:0] hit_data;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // live_q keeps host_ready low until the first clock after reset release.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(WBUF_DEPTH));
  assign wr_ready   = live_q && !fifo_full;
  assign rd_ready   = live_q && (state_q == IDLE) && fifo_empty;
  assign host_ready = host_we ? wr_ready : rd_ready;
  assign push       = host_req && host_we && wr_ready;
  assign rd_accept  = host_req && !host_we && rd_ready;
  assign in_entry   = {host_addr[14:2], host_addr[1:0], host_wdata};

  // An incoming write with an empty FIFO bypasses storage straight to the bus.
  assign wr_entry   = fifo_empty ? in_entry : fifo_q[rd_ptr_q];
  assign fifo_store = push && !(fifo_empty && issue_wr);

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE, WRITE: begin
        if (!fifo_empty || push) begin
          issue_wr = 1'b1;
          pop      = !fifo_empty;
          state_d  = WRITE;
        end else begin
          state_d = IDLE;
          if (rd_accept && !rd_hit) begin
            issue_rd = 1'b1;
            state_d  = RD_ISSUE;
          end
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (fifo_store) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)        rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CW'(fifo_store) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_store) fifo_q[wr_ptr_q] <= in_entry;
  end

  // Memory strobes are registered; address, lanes and data hold between accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      rd_lane_q      <= '0;
      host_rvalid    <= 1'b0;
      host_rdata     <= '0;
    end else begin
      mem_chipselect <= issue_wr || issue_rd;
      mem_write      <= issue_wr;
      host_rvalid    <= 1'b0;
      if (issue_wr) begin
        mem_address    <= wr_entry.word;
        mem_byteenable <= 4'b0001 << wr_entry.lane;
        mem_writedata  <= {4{wr_entry.data}};
      end else if (issue_rd) begin
        mem_address    <= host_addr[14:2];
        mem_byteenable <= 4'b0001 << host_addr[1:0];
        rd_lane_q      <= host_addr[1:0];
      end
      if (capture) begin
        host_rdata  <= mem_readdata[{rd_lane_q, 3'b000} +: 8];
        host_rvalid <= 1'b1;
      end else if (rd_accept && rd_hit) begin
        host_rdata  <= hit_data;
        host_rvalid <= 1'b1;
      end
    end
  end

`ifdef BRIDGE_READ_CACHE_EN
  logic        line_vld_q;
  logic [12:0] line_tag_q;
  logic [31:0] line_data_q;

  assign rd_hit   = line_vld_q && (line_tag_q == host_addr[14:2]);
  assign hit_data = line_data_q[{host_addr[1:0], 3'b000} +: 8];

  // A fill races with writes still queued behind it, so such a fill invalidates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     line_vld_q <= 1'b0;
    else if (capture) line_vld_q <= fifo_empty && !push;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      line_tag_q  <= mem_address;
      line_data_q <= mem_readdata;
    end else if (push && line_vld_q && (line_tag_q == in_entry.word)) begin
      line_data_q[{in_entry.lane, 3'b000} +: 8] <= in_entry.data;
    end
  end
`else
  assign rd_hit   = 1'b0;
  assign hit_data = '0;
`endif

endmodule
